// File: rtl/bcdc_pkg.sv
// Shared digit type, BCD constants and the per-digit legality check for the
// multi-digit BCD up/down counter.
package bcdc_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: steps by one when cin_i is set, in the
// direction given by up_i, and reports carry/borrow to the next digit.
module bcd_digit
  import bcdc_pkg::*;
(
  input  bcd_digit_t val_i,
  input  logic       cin_i,
  input  logic       up_i,
  output bcd_digit_t nxt_o,
  output logic       cout_o
);

  always_comb begin
    nxt_o  = val_i;
    cout_o = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (val_i >= BCD_MAX) begin
          nxt_o  = '0;
          cout_o = 1'b1;
        end else begin
          nxt_o = val_i + 4'd1;
        end
      end else begin
        if (val_i == '0) begin
          nxt_o  = BCD_MAX;
          cout_o = 1'b1;
        end else begin
          nxt_o = val_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised BCD up/down counter with runtime modulus, validated load, clear,
// and registered TC/ERR pulses. Define BCDC_SAT_EN for saturating (non-wrapping) mode.
module bcd_updown_counter
  import bcdc_pkg::*;
#(
  parameter  int DIGITS = 2,
  localparam int W      = DIGIT_W * DIGITS
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         EN,
  input  logic         UP,
  input  logic         CLR,
  input  logic         LD,
  input  logic [W-1:0] D,
  input  logic [W-1:0] LIMIT,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         ERR,
  output logic         ZERO
);

  logic [W-1:0]  q_q, q_d;
  logic          tc_q, tc_d;
  logic          err_q, err_d;
  logic [W-1:0]  step_val;
  logic [DIGITS:0] cy;
  logic [W-1:0]  eff_lim;
  logic          lim_ok, d_digits_ok, d_ok;
  logic          q_ge_lim, q_gt_lim;

  always_comb begin
    lim_ok      = 1'b1;
    d_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lim_ok      = lim_ok & bcd_valid(LIMIT[DIGIT_W*i +: DIGIT_W]);
      d_digits_ok = d_digits_ok & bcd_valid(D[DIGIT_W*i +: DIGIT_W]);
    end
  end

  // Both operands are legal BCD, so plain unsigned compares order them correctly.
  assign eff_lim  = lim_ok ? LIMIT : {DIGITS{BCD_MAX}};
  assign d_ok     = d_digits_ok && (D <= eff_lim);
  assign q_ge_lim = (q_q >= eff_lim);
  assign q_gt_lim = (q_q > eff_lim);

  assign cy[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .val_i  (q_q[DIGIT_W*g +: DIGIT_W]),
      .cin_i  (cy[g]),
      .up_i   (UP),
      .nxt_o  (step_val[DIGIT_W*g +: DIGIT_W]),
      .cout_o (cy[g+1])
    );
  end

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    err_d = 1'b0;
    if (CLR) begin
      q_d = '0;
    end else if (LD) begin
      if (d_ok) q_d = D;
      else      err_d = 1'b1;
    end else if (EN) begin
      if (UP) begin
        if (q_ge_lim) begin
`ifdef BCDC_SAT_EN
          q_d = eff_lim;
`else
          q_d = '0;
`endif
          tc_d = 1'b1;
        end else begin
          q_d = step_val;
        end
      end else begin
        // A borrow out of the top digit means the count was already zero.
        if (cy[DIGITS]) begin
`ifdef BCDC_SAT_EN
          q_d = '0;
`else
          q_d = eff_lim;
`endif
          tc_d = 1'b1;
        end else if (q_gt_lim) begin
          q_d = eff_lim;
        end else begin
          q_d = step_val;
        end
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      err_q <= err_d;
    end
  end

  assign Q    = q_q;
  assign TC   = tc_q;
  assign ERR  = err_q;
  assign ZERO = (q_q == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a 2-digit instance driven from a vector
// table plus a 100-edge sweep, and a 3-digit instance for load validation and reset.
module tb_bcd_updown_counter;

`ifdef BCDC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic ck = 1'b0;
  logic rn = 1'b1;

  logic       en2 = 0, up2 = 0, clr2 = 0, ld2 = 0;
  logic [7:0] d2 = '0, lim2 = 8'h99;
  logic [7:0] q2;
  logic       tc2, err2, zero2;

  logic        en3 = 0, up3 = 0, clr3 = 0, ld3 = 0;
  logic [11:0] d3 = '0, lim3 = 12'h999;
  logic [11:0] q3;
  logic        tc3, err3, zero3;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       clr, ld, en, up;
    logic [7:0] d, lim, q;
    logic       tc, err;
  } vec_t;
  vec_t vecs[$];

  always #5 ck = ~ck;

  bcd_updown_counter #(.DIGITS(2)) u_dut2 (
    .CK(ck), .RN(rn), .EN(en2), .UP(up2), .CLR(clr2), .LD(ld2),
    .D(d2), .LIMIT(lim2), .Q(q2), .TC(tc2), .ERR(err2), .ZERO(zero2)
  );

  bcd_updown_counter #(.DIGITS(3)) u_dut3 (
    .CK(ck), .RN(rn), .EN(en3), .UP(up3), .CLR(clr3), .LD(ld3),
    .D(d3), .LIMIT(lim3), .Q(q3), .TC(tc3), .ERR(err3), .ZERO(zero3)
  );

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check_v(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic clr, input logic ld, input logic en, input logic up,
                     input logic [7:0] d, input logic [7:0] lim, input logic [7:0] q,
                     input logic tc, input logic err);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.up = up;
    v.d = d; v.lim = lim; v.q = q; v.tc = tc; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic step3(input string name, input logic clr, input logic ld, input logic en,
                       input logic up, input logic [11:0] d, input logic [11:0] lim,
                       input logic [11:0] q, input logic tc, input logic err);
    clr3 = clr; ld3 = ld; en3 = en; up3 = up; d3 = d; lim3 = lim;
    tick();
    check_v({name, "_q"}, 16'(q3), 16'(q));
    check_b({name, "_tc"}, tc3, tc);
    check_b({name, "_err"}, err3, err);
  endtask

  initial begin
    int cnt;
    logic       etc;
    logic [7:0] eq;

    // Vector table for the 2-digit instance, starting from the state left by the sweep.
    //   clr ld en up  d      lim    q                         tc               err
    add(1, 0, 0, 0, 8'h00, 8'h99, 8'h00,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h23, SAT ? 8'h00 : 8'h23,        1,               0);
    add(0, 1, 0, 0, 8'h23, 8'h23, 8'h23,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h23, 8'h22,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h23, 8'h21,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h23, 8'h20,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h23, 8'h19,                      0,               0);
    add(0, 1, 0, 0, 8'h57, 8'h99, 8'h57,                      0,               0);
    add(0, 0, 1, 1, 8'h00, 8'h40, SAT ? 8'h40 : 8'h00,        1,               0);
    add(0, 1, 0, 0, 8'h57, 8'h99, 8'h57,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h40, 8'h40,                      0,               0);
    add(1, 1, 1, 1, 8'h12, 8'h99, 8'h00,                      0,               0);
    add(0, 1, 0, 0, 8'h3A, 8'h99, 8'h00,                      0,               1);
    add(0, 1, 0, 0, 8'h63, 8'h99, 8'h63,                      0,               0);
    add(0, 0, 0, 1, 8'h00, 8'h99, 8'h63,                      0,               0);
    add(0, 0, 1, 1, 8'h00, 8'h63, SAT ? 8'h63 : 8'h00,        1,               0);
    add(0, 0, 1, 1, 8'h00, 8'h00, 8'h00,                      1,               0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00,                      1,               0);
    add(0, 0, 1, 0, 8'h00, 8'hF0, SAT ? 8'h00 : 8'h99,        1,               0);
    add(0, 0, 1, 1, 8'h00, 8'hF0, SAT ? 8'h01 : 8'h00,        SAT ? 1'b0 : 1'b1, 0);
    add(0, 1, 0, 0, 8'h51, 8'h50, SAT ? 8'h01 : 8'h00,        0,               1);
    add(0, 1, 0, 0, 8'h50, 8'h50, 8'h50,                      0,               0);
    add(0, 1, 0, 0, 8'h19, 8'h99, 8'h19,                      0,               0);
    add(0, 0, 1, 1, 8'h00, 8'h99, 8'h20,                      0,               0);
    add(0, 1, 0, 0, 8'h03, 8'h05, 8'h03,                      0,               0);
    add(0, 0, 1, 1, 8'h00, 8'h05, 8'h04,                      0,               0);
    add(0, 0, 1, 1, 8'h00, 8'h05, 8'h05,                      0,               0);
    add(0, 0, 1, 1, 8'h00, 8'h05, SAT ? 8'h05 : 8'h00,        1,               0);
    add(0, 0, 1, 1, 8'h00, 8'h05, SAT ? 8'h05 : 8'h01,        SAT ? 1'b1 : 1'b0, 0);
    add(0, 1, 0, 0, 8'h01, 8'h05, 8'h01,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h05, 8'h00,                      0,               0);
    add(0, 0, 1, 0, 8'h00, 8'h05, SAT ? 8'h00 : 8'h05,        1,               0);
    add(0, 1, 0, 0, 8'h98, 8'hAB, 8'h98,                      0,               0);
    add(0, 0, 1, 1, 8'h00, 8'hAB, 8'h99,                      0,               0);

    // Asynchronous reset, sampled before any clock edge.
    #2 rn = 1'b0;
    #1;
    check_v("rst_q2", 16'(q2), 16'h0000);
    check_b("rst_tc2", tc2, 1'b0);
    check_b("rst_err2", err2, 1'b0);
    check_b("rst_zero2", zero2, 1'b1);
    check_v("rst_q3", 16'(q3), 16'h0000);
    check_b("rst_zero3", zero3, 1'b1);
    #9 rn = 1'b1;

    // Full 00..99 sweep with wrap on the 100th edge.
    en2 = 1; up2 = 1; lim2 = 8'h99;
    cnt = 0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (cnt == 99) begin
        cnt = SAT ? 99 : 0;
        etc = 1'b1;
      end else begin
        cnt = cnt + 1;
        etc = 1'b0;
      end
      eq = {4'(cnt / 10), 4'(cnt % 10)};
      check_v("sweep_q", 16'(q2), 16'(eq));
      check_b("sweep_tc", tc2, etc);
    end
    check_b("sweep_zero", zero2, SAT ? 1'b0 : 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      clr2 = vecs[i].clr; ld2 = vecs[i].ld; en2 = vecs[i].en; up2 = vecs[i].up;
      d2 = vecs[i].d; lim2 = vecs[i].lim;
      tick();
      check_v($sformatf("vec%0d_q", i), 16'(q2), 16'(vecs[i].q));
      check_b($sformatf("vec%0d_tc", i), tc2, vecs[i].tc);
      check_b($sformatf("vec%0d_err", i), err2, vecs[i].err);
      check_b($sformatf("vec%0d_zero", i), zero2, vecs[i].q == 8'h00);
    end
    clr2 = 0; ld2 = 0; en2 = 0; up2 = 0;

    // Three-digit load validation, wrap at a runtime limit, and clear priority.
    step3("ld_4a7", 0, 1, 0, 0, 12'h4A7, 12'h500, 12'h000, 0, 1);
    step3("ld_499", 0, 1, 0, 0, 12'h499, 12'h500, 12'h499, 0, 0);
    step3("ld_501", 0, 1, 0, 0, 12'h501, 12'h500, 12'h499, 0, 1);
    step3("up_500", 0, 0, 1, 1, 12'h000, 12'h500, 12'h500, 0, 0);
    step3("up_wrap", 0, 0, 1, 1, 12'h000, 12'h500, SAT ? 12'h500 : 12'h000, 1, 0);
    step3("clr_pri", 1, 1, 1, 1, 12'h111, 12'h999, 12'h000, 0, 0);
    step3("ld_063", 0, 1, 0, 0, 12'h063, 12'h999, 12'h063, 0, 0);
    step3("ld_bad", 0, 1, 0, 0, 12'h4A7, 12'h500, 12'h063, 0, 1);

    // Reset mid-count with LD still asserted cancels the pending ERR pulse.
    #2 rn = 1'b0;
    #1;
    check_v("midrst_q3", 16'(q3), 16'h0000);
    check_b("midrst_tc3", tc3, 1'b0);
    check_b("midrst_err3", err3, 1'b0);
    check_b("midrst_zero3", zero3, 1'b1);
    d3 = 12'h123;
    tick();
    check_v("midrst_hold_q3", 16'(q3), 16'h0000);
    check_b("midrst_hold_err3", err3, 1'b0);
    #2 rn = 1'b1;
    tick();
    check_v("post_rst_ld", 16'(q3), 16'h0123);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
